// File: rtl/mips_dump_pkg.sv
// mips_dump_pkg: shared state encoding and default widths for the memory dumper.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN adds the CSUM state.
package mips_dump_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_SEND,
    S_DONE
`ifdef MEM_DUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;
endpackage

// File: rtl/mips_mem_dumper_if.sv
// mips_mem_dumper_if: control, memory read port and output stream of the dumper.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN (no effect on this interface).
interface mips_mem_dumper_if #(
  parameter int ADDR_W = mips_dump_pkg::ADDR_W_DEF,
  parameter int DATA_W = mips_dump_pkg::DATA_W_DEF
);
  logic              halted;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;
  modport slave (
    input  halted, start, base_addr, word_count, mem_rd_data, out_ready,
    output mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done, err
  );
  modport master (
    output halted, start, base_addr, word_count, mem_rd_data, out_ready,
    input  mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done, err
  );
endinterface

// File: rtl/mips_mem_dumper.sv
// mips_mem_dumper: streams a block of data memory out while the processor is halted.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN appends an XOR checksum word.
module mips_mem_dumper
  import mips_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk1,
  input logic rst,
  mips_mem_dumper_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              accept, hs, last_w;
  assign accept = (state_q == S_IDLE) & bus.start & bus.halted;
  assign hs     = (state_q == S_SEND) & bus.out_ready;
  assign last_w = cnt_q == (ADDR_W+1)'(1);
  always_ff @(posedge clk1) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = !(bus.start & bus.halted) ? S_IDLE : (bus.word_count == '0) ? S_DONE : S_RD;
      S_RD:   state_d = bus.halted ? S_WAIT : S_IDLE;
      S_WAIT: state_d = S_SEND;
`ifdef MEM_DUMP_CHECKSUM_EN
      S_SEND: state_d = !hs ? S_SEND : last_w ? S_CSUM : S_RD;
      S_CSUM: state_d = bus.out_ready ? S_DONE : S_CSUM;
`else
      S_SEND: state_d = !hs ? S_SEND : last_w ? S_DONE : S_RD;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    bus.mem_rd_en   = (state_q == S_RD) & bus.halted;
    bus.mem_rd_addr = addr_q;
    bus.out_data    = data_q;
    bus.busy        = state_q != S_IDLE;
    bus.done        = state_q == S_DONE;
    bus.err         = err_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    bus.out_valid   = (state_q == S_SEND) | (state_q == S_CSUM);
    bus.out_last    = state_q == S_CSUM;
`else
    bus.out_valid   = state_q == S_SEND;
    bus.out_last    = (state_q == S_SEND) & last_w;
`endif
  end
  assign addr_d = accept ? bus.base_addr : hs ? addr_q + 1'b1 : addr_q;
  assign cnt_d  = accept ? bus.word_count : hs ? cnt_q - 1'b1 : cnt_q;
  assign err_d  = ((state_q == S_IDLE) & bus.start & !bus.halted) | ((state_q == S_RD) & !bus.halted);
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  assign csum_d = accept ? '0 : hs ? csum_q ^ data_q : csum_q;
  // the final handshake swaps the checksum into the output register for CSUM
  assign data_d = (state_q == S_WAIT) ? bus.mem_rd_data : (hs & last_w) ? csum_q ^ data_q : data_q;
  always_ff @(posedge clk1) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`else
  assign data_d = (state_q == S_WAIT) ? bus.mem_rd_data : data_q;
`endif
  always_ff @(posedge clk1) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_mips_mem_dumper.sv
// tb_mips_mem_dumper: scoreboard bench for mips_mem_dumper (honours MEM_DUMP_CHECKSUM_EN).
module tb_mips_mem_dumper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mips_mem_dumper_if bus ();
  mips_mem_dumper dut (.clk1(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  always @(posedge clk) if (bus.mem_rd_en) rd_q <= mem[bus.mem_rd_addr];
  assign bus.mem_rd_data = rd_q;
  int nchk = 0, nfail = 0, cyc = 0, rmode = 0;
  int n_done = 0, n_err = 0, n_hs = 0, n_valid = 0, done_cyc = 0, last_cyc = 0;
  logic [32:0] exp_q[$];
  logic [9:0]  addr_exp[$];
  logic        stall_prev = 1'b0;
  logic [32:0] prev_word;
  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask
  task automatic flag(string nm);
    nchk++;
    nfail++;
    $display("FAIL %s", nm);
  endtask
  task automatic push(logic [31:0] d, logic l);
    exp_q.push_back({l, d});
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'b0;
  end
  // monitor: pops the scoreboard whenever the DUT presents a read or a word
  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (bus.mem_rd_en) begin
        if (bus.out_valid) flag("rd_en_with_valid");
        if (addr_exp.size() == 0) flag("unexpected_read");
        else check("rd_addr", 64'(bus.mem_rd_addr), 64'(addr_exp.pop_front()));
      end
      if (bus.out_valid) begin
        n_valid++;
        if (stall_prev) check("stall_stable", 64'({bus.out_last, bus.out_data}), 64'(prev_word));
        if (bus.out_ready) begin
          n_hs++;
          if (bus.out_last) last_cyc = cyc;
          if (exp_q.size() == 0) flag("unexpected_word");
          else check("word", 64'({bus.out_last, bus.out_data}), 64'(exp_q.pop_front()));
        end
      end
      stall_prev = bus.out_valid & !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.err) n_err++;
    end
  end
  task automatic start_dump(logic [9:0] b, logic [10:0] c);
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.word_count = c;
    @(posedge clk) #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_end(string nm, int exp_done, int exp_err);
    int d0 = n_done, e0 = n_err;
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (n_done != d0 || n_err != e0) break;
    end
    if (k == 300) flag({nm, "_timeout"});
    @(negedge clk);
    check({nm, "_done"}, 64'(n_done - d0), 64'(exp_done));
    check({nm, "_err"}, 64'(n_err - e0), 64'(exp_err));
    check({nm, "_busy"}, 64'(bus.busy), 64'(0));
    check({nm, "_words_left"}, 64'(exp_q.size() + addr_exp.size()), 64'(0));
  endtask
  task automatic push_542(logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
    push(w1, 1'b0);
    push(w2, 1'b0);
`ifdef MEM_DUMP_CHECKSUM_EN
    push(w3, 1'b0);
    push(32'd5044, 1'b1);
`else
    push(w3, 1'b1);
`endif
    addr_exp.push_back(10'd198);
    addr_exp.push_back(10'd199);
    addr_exp.push_back(10'd200);
  endtask
  initial begin
    int k;
    int v0;
    bus.halted = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 7 + 1);
    mem[198] = 32'd5040;
    mem[199] = 32'd3;
    mem[200] = 32'd7;
    mem[1023] = 32'hAAAA0001;
    mem[0] = 32'h55550002;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", 64'({bus.mem_rd_en, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.err}), 64'(0));
    check("rst_data", 64'({bus.mem_rd_addr, bus.out_data}), 64'(0));
    @(posedge clk) #1 rst = 1'b0;
    push_542(32'd5040, 32'd3, 32'd7);
    start_dump(10'd198, 11'd3);
    @(posedge clk);
    @(negedge clk);
    check("valid_not_early", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    check("first_valid_lat", 64'(bus.out_valid), 64'(1));
    wait_end("basic", 1, 0);
    check("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    rmode = 1;
    push_542(32'd5040, 32'd3, 32'd7);
    start_dump(10'd198, 11'd3);
    wait_end("stall", 1, 0);
    rmode = 0;
    bus.halted = 1'b0;
    start_dump(10'd5, 11'd4);
    wait_end("not_halted", 0, 1);
    bus.halted = 1'b1;
    push(32'hAAAA0001, 1'b0);
`ifdef MEM_DUMP_CHECKSUM_EN
    push(32'h55550002, 1'b0);
    push(32'hFFFF0003, 1'b1);
`else
    push(32'h55550002, 1'b1);
`endif
    addr_exp.push_back(10'd1023);
    addr_exp.push_back(10'd0);
    start_dump(10'd1023, 11'd2);
    wait_end("wrap", 1, 0);
    v0 = n_valid;
    start_dump(10'd50, 11'd0);
    wait_end("zero_cnt", 1, 0);
    check("zero_cnt_novalid", 64'(n_valid - v0), 64'(0));
    push(32'd5040, 1'b0);
    push(32'd3, 1'b0);
    addr_exp.push_back(10'd198);
    addr_exp.push_back(10'd199);
    start_dump(10'd198, 11'd3);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_data == 32'd3) break;
    end
    if (k == 50) flag("abort_wait_timeout");
    bus.halted = 1'b0;
    wait_end("abort", 0, 1);
    bus.halted = 1'b1;
    rmode = 2;
    addr_exp.push_back(10'd198);
    start_dump(10'd198, 11'd3);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    if (k == 50) flag("rst_wait_timeout");
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    check("rst_mid_state", 64'({bus.busy, bus.out_data}), 64'(0));
    rst = 1'b0;
    rmode = 0;
    exp_q.delete();
    check("rst_mid_reads", 64'(addr_exp.size()), 64'(0));
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/mips_mem_dumper.md
MIPS_MEM_DUMPER -- requirements
Module: mips_mem_dumper

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the memory word-address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the memory word width.
REQ-003 clk1  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 halted  input  1  processor HALTED flag; a dump is permitted only while it is 1.
REQ-006 start  input  1  single-cycle dump request.
REQ-007 base_addr  input  ADDR_W  first word address, sampled on an accepted start.
REQ-008 word_count  input  ADDR_W+1  number of words, 0..2^ADDR_W, sampled on an accepted start.
REQ-009 mem_rd_en  output  1  memory read strobe.
REQ-010 mem_rd_addr  output  ADDR_W  memory read word address.
REQ-011 mem_rd_data  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-012 out_valid  output  1  stream word valid.
REQ-013 out_data  output  DATA_W  stream word.
REQ-014 out_last  output  1  marks the final stream word.
REQ-015 out_ready  input  1  sink accepts the word when out_valid and out_ready are both 1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at normal completion.
REQ-018 err  output  1  one-cycle pulse on a rejected start or an abort.

Function
REQ-019 The FSM SHALL have the states IDLE, RD, WAIT, SEND, CSUM and DONE.
REQ-020 IDLE with start=1, halted=1 and word_count>0 SHALL latch the address and count, then go to RD.
REQ-021 IDLE with start=1, halted=1 and word_count=0 SHALL go to DONE with no read and no stream word.
REQ-022 IDLE with start=1 and halted=0 SHALL pulse err the next cycle, stay in IDLE and issue no read.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 RD SHALL drive mem_rd_en=1 and mem_rd_addr=current address for one cycle, then go to WAIT.
REQ-025 WAIT SHALL register mem_rd_data into out_data, then go to SEND.
REQ-026 SEND SHALL hold out_valid=1 with out_data stable until the handshake.
REQ-027 On the SEND handshake the block SHALL increment the address modulo 2^ADDR_W and decrement the remaining count.
REQ-028 After the SEND handshake the FSM SHALL go to RD if the remaining count is nonzero, else to CSUM when the macro is defined, else to DONE.
REQ-029 Minimum throughput SHALL be one word per 3 cycles; first out_valid SHALL occur 3 cycles after the accepted start.
REQ-030 out_last SHALL be 1 only on the final stream word: the last memory word, or the checksum word when enabled.
REQ-031 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-032 halted=0 sampled in RD SHALL abort the dump: no read, err pulse, return to IDLE, no out_last.
REQ-033 halted is not checked in WAIT or SEND; an in-flight word SHALL complete its handshake first.
REQ-034 mem_rd_en SHALL never be 1 while out_valid=1.

Reset
REQ-035 rst=1 SHALL force IDLE and clear all of these: mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done, err, the internal address, the count and the checksum.
REQ-036 Reset during a dump SHALL drop out_valid in the next cycle without completing the handshake.

Configuration
REQ-037 When MEM_DUMP_CHECKSUM_EN is defined, the block SHALL keep a running XOR of all streamed words (cleared on an accepted start) and SEND it as one extra word in CSUM with out_last=1.
REQ-038 When MEM_DUMP_CHECKSUM_EN is undefined, CSUM and the checksum register SHALL be absent and the last memory word SHALL carry out_last.
REQ-039 A word_count=0 dump SHALL emit no checksum word in either configuration.

Structure
REQ-040 The state encoding enum and the defaults for ADDR_W and DATA_W SHALL live in the shared package mips_dump_pkg.
REQ-041 The block SHALL be a single module; the 1-cycle-latency memory read port SHALL be connected by the parent (the processor data memory) or by the bench.

Verification
REQ-042 Memory with [198]=5040, [199]=3 and [200]=7, halted=1, base=198, count=3, out_ready=1: the bench SHALL see 5040, 3, 7 with out_last on 7 and done 1 cycle after.
REQ-043 Same stimulus with out_ready toggling 1-of-3 cycles: the bench SHALL see identical data with out_data stable while stalled and no mem_rd_en during stalls.
REQ-044 Start with halted=0: the bench SHALL see an err pulse, no mem_rd_en and busy=0.
REQ-045 base=1023, count=2: the bench SHALL see reads of addresses 1023 then 0; start with count=0: the bench SHALL see done with no out_valid.
REQ-046 With MEM_DUMP_CHECKSUM_EN and words 5040, 3, 7: the bench SHALL see a 4th word equal to 5040^3^7 carrying out_last.
REQ-047 halted dropped during a 3-word dump while the 2nd word is in SEND: the bench SHALL see the 2nd word complete, then err, no out_last and IDLE.
